// File: rtl/pwm_duty_decoder_pkg.sv
// Shared definitions for the PWM receive path: FSM state encoding and the
// nominal-period helper that the generator side also uses for its resolution.
package pwm_duty_decoder_pkg;

  // Measurement FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for the first rising edge, nothing measured yet
    ST_HIGH = 2'd1,  // inside the high phase, counting high ticks
    ST_LOW  = 2'd2   // inside the low phase, waiting for the closing rise
  } state_t;

  // Nominal PWM period in ticks for a free-running 2**res_bits counter.
  function automatic int unsigned nominal_period(input int unsigned res_bits);
    return 32'd1 << res_bits;
  endfunction

endpackage

// File: rtl/pwm_duty_decoder_sync.sv
// Multi-flop synchronizer bringing the asynchronous PWM input into the clk
// domain. Runs every clk, independent of the tick enable.
module pwm_duty_decoder_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain; all stages clear on reset.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbour; = here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: recovers the compare value of a PWM waveform produced by a
// free-running 2**RESOLUTION_BITS counter. The input is synchronized, edges are
// detected on ena ticks, high time and period are measured in ticks, and the
// result is published with a one-clk valid pulse. Periods other than the
// nominal one raise period_err; a missing edge for TIMEOUT_TICKS reports a
// stuck 0% or 100% level.
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int RESOLUTION_BITS = 8,
  parameter int CNT_BITS        = RESOLUTION_BITS + 2,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_TICKS   = 2 ** (RESOLUTION_BITS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       pwm_in,
  output logic [RESOLUTION_BITS-1:0] duty,
  output logic [CNT_BITS-1:0]        period,
  output logic                       valid,
  output logic                       period_err,
  output logic                       stuck_lo,
  output logic                       stuck_hi
);

  // Counter constants sized to the run counter so comparisons are width-exact.
  localparam logic [CNT_BITS-1:0] NOMINAL_PERIOD =
    CNT_BITS'(nominal_period(RESOLUTION_BITS));
  localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX      = '1;

  // Synchronized level and its value at the previous ena tick.
  logic s;
  logic p;

  // Edge and timeout qualifiers for the current tick.
  logic rise;
  logic fall;
  logic timeout_hit;

  // Ticks since the last rising edge, saturating.
  logic [CNT_BITS-1:0] run_cnt;

  // High time latched at the falling edge; only the duty-width bits matter,
  // an over-long high phase is flagged through period_err instead.
  logic [RESOLUTION_BITS-1:0] high_lat;

  state_t state;

  pwm_duty_decoder_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pwm_in),
    .q   (s)
  );

  // Edge detect against the level seen at the previous tick, plus the
  // timeout condition; a timeout is only declared on a tick with no edge.
  // NOTE: every signal assigned here gets a value on every path, so no latch
  // is inferred for the combinational qualifiers.
  always_comb begin
    rise        = s & ~p;
    fall        = ~s & p;
    timeout_hit = (run_cnt == TIMEOUT_LAST) && !(rise || fall);
  end

  // Remember the synchronized level at each tick for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= 1'b0;
    end else if (ena) begin
      p <= s;
    end
  end

  // Run counter: restarts at 1 on the rise tick so that the pre-update value
  // at the following fall (or rise) equals the high time (or period) in ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (ena) begin
      if (rise) begin
        run_cnt <= CNT_BITS'(1);
      end else if (run_cnt != CNT_MAX) begin
        run_cnt <= run_cnt + CNT_BITS'(1);
      end
    end
  end

  // Measurement FSM with registered outputs. Timeout takes priority in every
  // state; otherwise IDLE waits for a rise, HIGH latches the high time at the
  // fall, and LOW publishes a full measurement at the closing rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      high_lat   <= '0;
      duty       <= '0;
      period     <= '0;
      valid      <= 1'b0;
      period_err <= 1'b0;
      stuck_lo   <= 1'b0;
      stuck_hi   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (ena) begin
        if (timeout_hit) begin
          // No edge for the whole timeout window: report the held level as a
          // 0% or 100% duty; period and period_err keep their last values.
          state    <= ST_IDLE;
          valid    <= 1'b1;
          stuck_lo <= ~s;
          stuck_hi <= s;
          duty     <= s ? '1 : '0;
        end else begin
          case (state)
            ST_IDLE: begin
              // The first rise only opens a measurement window.
              if (rise) begin
                state <= ST_HIGH;
              end
            end
            ST_HIGH: begin
              if (fall) begin
                high_lat <= run_cnt[RESOLUTION_BITS-1:0];
                state    <= ST_LOW;
              end
            end
            ST_LOW: begin
              if (rise) begin
                period     <= run_cnt;
                duty       <= high_lat;
                period_err <= (run_cnt != NOMINAL_PERIOD);
                stuck_lo   <= 1'b0;
                stuck_hi   <= 1'b0;
                valid      <= 1'b1;
                state      <= ST_HIGH;
              end
            end
            default: begin
              state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder at RESOLUTION_BITS=8. Waveforms are
// played tick by tick; valid pulses are counted as they appear and the held
// outputs are compared against hand-computed values after each scenario.
module tb_pwm_duty_decoder;

  localparam int RES = 8;
  localparam int CB  = RES + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          pwm_in = 1'b0;
  logic [RES-1:0] duty;
  logic [CB-1:0]  period;
  logic          valid;
  logic          period_err;
  logic          stuck_lo;
  logic          stuck_hi;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int gap_bad = 0;

  pwm_duty_decoder #(
    .RESOLUTION_BITS (RES),
    .CNT_BITS        (CB),
    .SYNC_STAGES     (2),
    .TIMEOUT_TICKS   (512)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .period     (period),
    .valid      (valid),
    .period_err (period_err),
    .stuck_lo   (stuck_lo),
    .stuck_hi   (stuck_hi)
  );

  always #5 clk = ~clk;

  // Advance one clk, sampling on the falling edge and counting valid pulses.
  task automatic step();
    @(negedge clk);
    if (valid === 1'b1) vcount++;
  endtask

  // One ena tick at the given level; gap-1 idle clocks precede the enabled clk.
  // Idle clocks must leave outputs untouched with valid low.
  task automatic tick(input logic level, input int gap);
    logic [RES-1:0] d0;
    logic [CB-1:0]  p0;
    pwm_in = level;
    for (int i = 0; i < gap; i++) begin
      ena = (i == gap - 1);
      d0 = duty;
      p0 = period;
      step();
      if (i != gap - 1) begin
        if (valid !== 1'b0 || duty !== d0 || period !== p0) gap_bad++;
      end
    end
  endtask

  task automatic play(input int high, input int per, input int n, input int gap);
    for (int k = 0; k < n; k++)
      for (int t = 0; t < per; t++)
        tick(t < high, gap);
  endtask

  task automatic hold(input logic level, input int n, input int gap);
    for (int k = 0; k < n; k++) tick(level, gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vcount = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({duty, period, valid, period_err, stuck_lo, stuck_hi} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got duty=%0d period=%0d v=%b e=%b lo=%b hi=%b expected all 0",
               duty, period, valid, period_err, stuck_lo, stuck_hi);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    play(64, 256, 3, 1);
    total++;
    if (vcount !== 2) begin bad++; $display("FAIL nominal_valid_count: got %0d expected 2", vcount); end
    total++;
    if (duty !== 8'd64) begin bad++; $display("FAIL nominal_duty: got %0d expected 64", duty); end
    total++;
    if (period !== 10'd256) begin bad++; $display("FAIL nominal_period: got %0d expected 256", period); end
    total++;
    if (period_err !== 1'b0) begin bad++; $display("FAIL nominal_err: got %b expected 0", period_err); end
  endtask

  task automatic test_stuck();
    do_reset();
    hold(1'b0, 600, 1);
    total++;
    if (vcount !== 1) begin bad++; $display("FAIL stuck_lo_valid_count: got %0d expected 1", vcount); end
    total++;
    if ({stuck_lo, stuck_hi} !== 2'b10) begin bad++; $display("FAIL stuck_lo_flags: got lo=%b hi=%b expected lo=1 hi=0", stuck_lo, stuck_hi); end
    total++;
    if (duty !== 8'd0) begin bad++; $display("FAIL stuck_lo_duty: got %0d expected 0", duty); end
    total++;
    if (period !== 10'd0 || period_err !== 1'b0) begin bad++; $display("FAIL stuck_lo_period_hold: got period=%0d err=%b expected 0/0", period, period_err); end

    do_reset();
    play(255, 256, 3, 1);
    total++;
    if (duty !== 8'd255 || period !== 10'd256 || period_err !== 1'b0) begin
      bad++;
      $display("FAIL duty255: got duty=%0d period=%0d err=%b expected 255/256/0", duty, period, period_err);
    end

    do_reset();
    hold(1'b1, 600, 1);
    total++;
    if (vcount !== 1) begin bad++; $display("FAIL stuck_hi_valid_count: got %0d expected 1", vcount); end
    total++;
    if ({stuck_lo, stuck_hi} !== 2'b01) begin bad++; $display("FAIL stuck_hi_flags: got lo=%b hi=%b expected lo=0 hi=1", stuck_lo, stuck_hi); end
    total++;
    if (duty !== 8'd255) begin bad++; $display("FAIL stuck_hi_duty: got %0d expected 255", duty); end
  endtask

  task automatic test_bad_period();
    do_reset();
    play(10, 200, 3, 1);
    total++;
    if (vcount !== 2) begin bad++; $display("FAIL badper_valid_count: got %0d expected 2", vcount); end
    total++;
    if (duty !== 8'd10 || period !== 10'd200 || period_err !== 1'b1) begin
      bad++;
      $display("FAIL badper_values: got duty=%0d period=%0d err=%b expected 10/200/1", duty, period, period_err);
    end
  endtask

  task automatic test_ena_gaps();
    do_reset();
    gap_bad = 0;
    play(128, 256, 3, 3);
    ena = 1'b0;
    total++;
    if (duty !== 8'd128 || period !== 10'd256 || period_err !== 1'b0) begin
      bad++;
      $display("FAIL gap_values: got duty=%0d period=%0d err=%b expected 128/256/0", duty, period, period_err);
    end
    total++;
    if (gap_bad !== 0) begin bad++; $display("FAIL gap_hold: got %0d disturbed idle clks expected 0", gap_bad); end
    total++;
    if (vcount !== 2) begin bad++; $display("FAIL gap_valid_count: got %0d expected 2", vcount); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    play(64, 256, 1, 1);
    hold(1'b1, 30, 1);
    total++;
    if (duty !== 8'd64 || period !== 10'd256) begin
      bad++;
      $display("FAIL midrst_pre: got duty=%0d period=%0d expected 64/256", duty, period);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({duty, period, valid, period_err, stuck_lo, stuck_hi} !== '0) begin
      bad++;
      $display("FAIL midrst_clear: got duty=%0d period=%0d v=%b e=%b lo=%b hi=%b expected all 0",
               duty, period, valid, period_err, stuck_lo, stuck_hi);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    hold(1'b1, 34, 1);
    hold(1'b0, 192, 1);
    total++;
    if (vcount !== 0) begin bad++; $display("FAIL midrst_early_valid: got %0d expected 0", vcount); end
    play(64, 256, 1, 1);
    total++;
    if (vcount !== 1 || period_err !== 1'b1) begin
      bad++;
      $display("FAIL midrst_second_rise: got count=%0d err=%b expected 1/1", vcount, period_err);
    end
    play(64, 256, 1, 1);
    total++;
    if (vcount !== 2 || duty !== 8'd64 || period !== 10'd256 || period_err !== 1'b0) begin
      bad++;
      $display("FAIL midrst_recover: got count=%0d duty=%0d period=%0d err=%b expected 2/64/256/0",
               vcount, duty, period, period_err);
    end
  endtask

  task automatic test_stuck_recover();
    do_reset();
    hold(1'b0, 600, 1);
    total++;
    if (stuck_lo !== 1'b1) begin bad++; $display("FAIL recover_stuck_set: got %b expected 1", stuck_lo); end
    play(32, 256, 1, 1);
    total++;
    if (stuck_lo !== 1'b1 || vcount !== 1) begin
      bad++;
      $display("FAIL recover_flag_kept: got lo=%b count=%0d expected 1/1", stuck_lo, vcount);
    end
    play(32, 256, 1, 1);
    total++;
    if (vcount !== 2 || stuck_lo !== 1'b0 || stuck_hi !== 1'b0) begin
      bad++;
      $display("FAIL recover_flags_clear: got count=%0d lo=%b hi=%b expected 2/0/0", vcount, stuck_lo, stuck_hi);
    end
    total++;
    if (duty !== 8'd32 || period !== 10'd256 || period_err !== 1'b0) begin
      bad++;
      $display("FAIL recover_values: got duty=%0d period=%0d err=%b expected 32/256/0", duty, period, period_err);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stuck();
    test_bad_period();
    test_ena_gaps();
    test_mid_reset();
    test_stuck_recover();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
